// File: rtl/button_select_n.sv
// Debounced N-button selector: synchronizes and debounces each button, then a small FSM
// accepts a single press as a held one-hot/binary selection and flags simultaneous presses.
module button_select_n #(
    parameter int unsigned N_BTN      = 4,
    parameter int unsigned DEB_CYCLES = 4
) (
    input  logic                                            clk,
    input  logic                                            reset,
    input  logic [N_BTN-1:0]                                btn_in,
    input  logic                                            sel_clr,
    output logic [N_BTN-1:0]                                sel_code,
    output logic [(($clog2(N_BTN) < 1) ? 1 : $clog2(N_BTN))-1:0] sel_idx,
    output logic                                            sel_valid,
    output logic                                            op_active,
    output logic                                            multi_err
);

    localparam int unsigned IDX_W = ($clog2(N_BTN) < 1) ? 1 : $clog2(N_BTN);
    localparam int unsigned CNT_W = ($clog2(DEB_CYCLES) < 1) ? 1 : $clog2(DEB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    typedef enum logic [1:0] {
        StIdle,
        StActive,
        StConflict
    } state_e;

    logic [N_BTN-1:0] sync1_q, sync2_q, deb_q;
    logic [CNT_W-1:0] cnt_q [N_BTN];

    state_e           state_q, state_d;
    logic [N_BTN-1:0] code_q, code_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             valid_q, valid_d;
    logic [N_BTN-1:0] held_q, held_d;

    logic             none_pressed, one_pressed, multi_pressed;
    logic [N_BTN-1:0] press_code;
    logic [IDX_W-1:0] press_idx;
    logic             accept;

    // Counter tracks consecutive cycles the synchronized level disagrees with the debounced one.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            deb_q   <= '0;
            for (int i = 0; i < int'(N_BTN); i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q <= btn_in;
            sync2_q <= sync1_q;
            for (int i = 0; i < int'(N_BTN); i++) begin
                if (sync2_q[i] == deb_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] == CNT_LAST) begin
                    cnt_q[i] <= '0;
                    deb_q[i] <= sync2_q[i];
                end else begin
                    cnt_q[i] <= cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        none_pressed  = (deb_q == '0);
        one_pressed   = !none_pressed && ((deb_q & (deb_q - N_BTN'(1))) == '0);
        multi_pressed = !none_pressed && !one_pressed;
        press_idx     = '0;
        press_code    = '0;
        for (int i = 0; i < int'(N_BTN); i++) begin
            press_code[int'(N_BTN) - 1 - i] = deb_q[i];
            if (deb_q[i]) begin
                press_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        code_d  = sel_clr ? '0 : code_q;
        idx_d   = sel_clr ? '0 : idx_q;
        held_d  = held_q;
        valid_d = 1'b0;
        accept  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (multi_pressed) begin
                    state_d = StConflict;
                end else if (one_pressed) begin
                    state_d = StActive;
                    accept  = 1'b1;
                end
            end
            StActive: begin
                if (multi_pressed) begin
                    state_d = StConflict;
                end else if (none_pressed) begin
                    state_d = StIdle;
                end else if (deb_q != held_q) begin
                    accept = 1'b1;
                end
            end
            StConflict: begin
                // Lockout: only a full release re-arms selection.
                if (none_pressed) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        if (accept) begin
            code_d  = press_code;
            idx_d   = press_idx;
            held_d  = deb_q;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            code_q  <= '0;
            idx_q   <= '0;
            held_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            idx_q   <= idx_d;
            held_q  <= held_d;
            valid_q <= valid_d;
        end
    end

    assign sel_code  = code_q;
    assign sel_idx   = idx_q;
    assign sel_valid = valid_q;
    assign op_active = (state_q == StActive);
    assign multi_err = (state_q == StConflict);

endmodule

// File: tb/tb_button_select_n.sv
// Self-checking bench for button_select_n (N_BTN=4, DEB_CYCLES=4) with a cycle-level
// reference model built from the press history rather than from the RTL structure.
module tb_button_select_n;

    localparam int N = 4;
    localparam int D = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] btn_in = '0;
    logic       sel_clr = 1'b0;
    logic [3:0] sel_code;
    logic [1:0] sel_idx;
    logic       sel_valid, op_active, multi_err;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Reference model state
    logic [3:0] hist [$];
    logic [3:0] m_deb, m_code;
    logic [1:0] m_idx;
    logic       m_valid;
    int         m_mode;  // 0 none held, 1 one accepted, 2 conflict
    int         m_btn;

    logic [8:0] act_v, exp_v;

    button_select_n #(.N_BTN(N), .DEB_CYCLES(D)) dut (
        .clk      (clk),
        .reset    (reset),
        .btn_in   (btn_in),
        .sel_clr  (sel_clr),
        .sel_code (sel_code),
        .sel_idx  (sel_idx),
        .sel_valid(sel_valid),
        .op_active(op_active),
        .multi_err(multi_err)
    );

    always #5 clk = ~clk;

    assign act_v = {sel_code, sel_idx, sel_valid, op_active, multi_err};
    assign exp_v = {m_code, m_idx, m_valid, m_mode == 1, m_mode == 2};

    task automatic model_reset();
        hist.delete();
        for (int j = 0; j < D + 2; j++) hist.push_back(4'b0000);
        m_deb = '0; m_code = '0; m_idx = '0; m_valid = 1'b0; m_mode = 0; m_btn = -1;
    endtask

    // One rising edge: selection decisions use the debounced level from before the edge;
    // a bit's debounced level flips once the D samples taken 2..D+1 edges ago all disagree.
    task automatic model_edge();
        int n = $countones(m_deb);
        int who = -1;
        bit acc = 1'b0;
        int last;
        bit flip;
        for (int i = 0; i < N; i++) if (m_deb[i]) who = i;
        if (sel_clr) begin m_code = '0; m_idx = '0; end
        m_valid = 1'b0;
        case (m_mode)
            0: if (n == 1) begin acc = 1'b1; m_mode = 1; end else if (n >= 2) m_mode = 2;
            1: if (n >= 2) m_mode = 2; else if (n == 0) m_mode = 0; else if (who != m_btn) acc = 1'b1;
            default: if (n == 0) m_mode = 0;
        endcase
        if (acc) begin
            m_btn = who;
            m_code = 4'b0001 << (N - 1 - who);
            m_idx = 2'(who);
            m_valid = 1'b1;
        end
        hist.push_back(btn_in);
        last = hist.size() - 1;
        for (int b = 0; b < N; b++) begin
            flip = 1'b1;
            for (int j = 2; j <= D + 1; j++) if (hist[last - j][b] == m_deb[b]) flip = 1'b0;
            if (flip) m_deb[b] = ~m_deb[b];
        end
        while (hist.size() > D + 3) void'(hist.pop_front());
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if (act_v !== 9'b0) begin
            failures++;
            $display("FAIL reset_outputs got=%b want=%b", act_v, 9'b0);
        end
        model_reset();
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_single();
        btn_in = 4'b0001;
        for (int k = 1; k <= 7; k++) begin
            tick();
            checks++;
            if (act_v !== exp_v) begin
                failures++;
                $display("FAIL single_model cyc=%0d got=%b want=%b", cyc, act_v, exp_v);
            end
            if (k < 7) begin
                checks++;
                if ({sel_valid, op_active} !== 2'b00) begin
                    failures++;
                    $display("FAIL single_early k=%0d got=%b want=00", k, {sel_valid, op_active});
                end
            end
        end
        checks++;
        if ({sel_code, sel_idx, op_active, sel_valid} !== {4'b1000, 2'd0, 1'b1, 1'b1}) begin
            failures++;
            $display("FAIL single_accept got=%b want=%b",
                     {sel_code, sel_idx, op_active, sel_valid}, {4'b1000, 2'd0, 1'b1, 1'b1});
        end
        tick();
        checks++;
        if ({sel_valid, op_active} !== 2'b01) begin
            failures++;
            $display("FAIL single_pulse_width got=%b want=01", {sel_valid, op_active});
        end
        btn_in = 4'b0000;
        for (int k = 0; k < 10; k++) begin
            tick();
            checks++;
            if (act_v !== exp_v) begin
                failures++;
                $display("FAIL single_release cyc=%0d got=%b want=%b", cyc, act_v, exp_v);
            end
        end
    endtask

    task automatic test_glitch();
        logic [8:0] snap;
        snap = act_v;
        for (int g = 0; g < 4; g++) begin
            for (int k = 0; k < 6; k++) begin
                btn_in = (k < 3) ? 4'b0100 : 4'b0000;
                tick();
                checks++;
                if (act_v !== snap || act_v !== exp_v) begin
                    failures++;
                    $display("FAIL glitch_stable cyc=%0d got=%b want=%b", cyc, act_v, snap);
                end
            end
        end
        btn_in = 4'b0100;
        for (int k = 0; k < 10; k++) begin
            tick();
            checks++;
            if (act_v !== exp_v) begin
                failures++;
                $display("FAIL glitch_hold cyc=%0d got=%b want=%b", cyc, act_v, exp_v);
            end
        end
        checks++;
        if ({sel_code, sel_idx} !== {4'b0010, 2'd2}) begin
            failures++;
            $display("FAIL glitch_select got=%b want=%b", {sel_code, sel_idx}, {4'b0010, 2'd2});
        end
    endtask

    task automatic test_conflict();
        logic [3:0] pats [4];
        int pulses;
        pats[0] = 4'b0000; pats[1] = 4'b0011; pats[2] = 4'b0010; pats[3] = 4'b0000;
        for (int p = 0; p < 4; p++) begin
            btn_in = pats[p];
            for (int k = 0; k < 10; k++) begin
                tick();
                checks++;
                if (act_v !== exp_v) begin
                    failures++;
                    $display("FAIL conflict_model cyc=%0d got=%b want=%b", cyc, act_v, exp_v);
                end
            end
            if (p == 1 || p == 2) begin
                checks++;
                if ({multi_err, op_active, sel_code} !== {2'b10, 4'b0010}) begin
                    failures++;
                    $display("FAIL conflict_lock p=%0d got=%b want=%b", p,
                             {multi_err, op_active, sel_code}, {2'b10, 4'b0010});
                end
            end
            if (p == 3) begin
                checks++;
                if ({multi_err, op_active} !== 2'b00) begin
                    failures++;
                    $display("FAIL conflict_exit got=%b want=00", {multi_err, op_active});
                end
            end
        end
        btn_in = 4'b0010;
        pulses = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (sel_valid) pulses++;
        end
        checks++;
        if ({sel_code, sel_idx, op_active} !== {4'b0100, 2'd1, 1'b1} || pulses != 1) begin
            failures++;
            $display("FAIL conflict_reselect got=%b pulses=%0d want=%b pulses=1",
                     {sel_code, sel_idx, op_active}, pulses, {4'b0100, 2'd1, 1'b1});
        end
    endtask

    task automatic test_clr();
        btn_in = 4'b0000;
        for (int k = 0; k < 10; k++) tick();
        checks++;
        if ({sel_code, op_active, multi_err} !== {4'b0100, 2'b00}) begin
            failures++;
            $display("FAIL clr_setup got=%b want=%b", {sel_code, op_active, multi_err},
                     {4'b0100, 2'b00});
        end
        sel_clr = 1'b1;
        tick();
        sel_clr = 1'b0;
        checks++;
        if ({sel_code, sel_idx, sel_valid, op_active, multi_err} !== 9'b0 || act_v !== exp_v) begin
            failures++;
            $display("FAIL clr_zero got=%b want=%b", act_v, 9'b0);
        end
    endtask

    task automatic test_switch();
        int pulses;
        btn_in = 4'b0001;
        for (int k = 0; k < 10; k++) tick();
        checks++;
        if ({sel_code, op_active} !== {4'b1000, 1'b1}) begin
            failures++;
            $display("FAIL switch_setup got=%b want=%b", {sel_code, op_active}, {4'b1000, 1'b1});
        end
        btn_in = 4'b1000;
        pulses = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (sel_valid) pulses++;
            checks++;
            if (op_active !== 1'b1 || act_v !== exp_v) begin
                failures++;
                $display("FAIL switch_active cyc=%0d got=%b want=%b", cyc, act_v, exp_v);
            end
        end
        checks++;
        if ({sel_code, sel_idx} !== {4'b0001, 2'd3} || pulses != 1) begin
            failures++;
            $display("FAIL switch_select got=%b pulses=%0d want=%b pulses=1",
                     {sel_code, sel_idx}, pulses, {4'b0001, 2'd3});
        end
    endtask

    task automatic test_reset_active();
        checks++;
        if (op_active !== 1'b1) begin
            failures++;
            $display("FAIL rst_setup got=%b want=1", op_active);
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (act_v !== 9'b0) begin
            failures++;
            $display("FAIL rst_async got=%b want=%b", act_v, 9'b0);
        end
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            tick();
            checks++;
            if (sel_valid !== (k == 7) || act_v !== exp_v) begin
                failures++;
                $display("FAIL rst_reselect k=%0d got=%b want=%b", k, act_v, exp_v);
            end
        end
        checks++;
        if ({sel_code, sel_idx, op_active} !== {4'b0001, 2'd3, 1'b1}) begin
            failures++;
            $display("FAIL rst_final got=%b want=%b", {sel_code, sel_idx, op_active},
                     {4'b0001, 2'd3, 1'b1});
        end
    endtask

    task automatic test_random();
        int hold = 0;
        for (int k = 0; k < 800; k++) begin
            if (hold == 0) begin
                btn_in = ($urandom_range(0, 2) == 0) ? 4'(1 << $urandom_range(0, 3))
                                                     : 4'($urandom_range(0, 15));
                if ($urandom_range(0, 3) == 0) btn_in = 4'b0000;
                hold = $urandom_range(1, 12);
            end
            hold--;
            sel_clr = ($urandom_range(0, 7) == 0);
            tick();
            checks++;
            if (act_v !== exp_v) begin
                failures++;
                $display("FAIL random cyc=%0d btn=%b got=%b want=%b", cyc, btn_in, act_v, exp_v);
            end
        end
        sel_clr = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_glitch();
        test_conflict();
        test_clr();
        test_switch();
        test_reset_active();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
